// File: rtl/slave_bus_port.sv
// slave_bus_port: deserializes one arbiter frame, performs a single memory read or write,
// and serializes read data back on ready_o/data_out_o.
module slave_bus_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic                  address_i,
  input  logic                  data_i,
  output logic                  ready_o,
  output logic                  data_out_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int CW = $clog2(ADDR_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, RX, ACCESS, RDWAIT, TX, DONE, WAITLOW} state_t;
  state_t                state_q;
  logic                  rw_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d, tx_q;
  logic                  data_take;
  // Serial bits arrive LSB first, so each new bit enters at the top and walks down.
  assign data_take = rw_q && (cnt_q < CW'(DATA_WIDTH));
  assign addr_sh_d = {address_i, addr_sh_q[ADDR_WIDTH-1:1]};
  assign data_sh_d = data_take ? {data_i, data_sh_q[DATA_WIDTH-1:1]} : data_sh_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tx_q        <= '0;
      ready_o     <= 1'b0;
      data_out_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      mem_re_o <= 1'b0;
      case (state_q)
        IDLE: if (valid_i) begin
          rw_q    <= address_i;
          cnt_q   <= '0;
          state_q <= RX;
        end
        RX: if (!valid_i) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          addr_sh_q <= '0;
          data_sh_q <= '0;
        end else begin
          addr_sh_q <= addr_sh_d;
          data_sh_q <= data_sh_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            state_q     <= ACCESS;
            mem_addr_o  <= addr_sh_d;
            mem_wdata_o <= data_sh_d;
            mem_we_o    <= rw_q;
            mem_re_o    <= !rw_q;
          end
        end
        ACCESS: begin
          cnt_q   <= '0;
          ready_o <= rw_q;
          state_q <= rw_q ? DONE : RDWAIT;
        end
        RDWAIT: if (cnt_q == CW'(READ_LATENCY - 1)) begin
          cnt_q      <= '0;
          state_q    <= TX;
          ready_o    <= 1'b1;
          data_out_o <= mem_rdata_i[0];
          tx_q       <= mem_rdata_i >> 1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        TX: if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_q    <= WAITLOW;
          ready_o    <= 1'b0;
          data_out_o <= 1'b0;
        end else begin
          cnt_q      <= cnt_q + 1'b1;
          data_out_o <= tx_q[0];
          tx_q       <= tx_q >> 1;
        end
        DONE: begin
          ready_o <= 1'b0;
          state_q <= WAITLOW;
        end
        WAITLOW: if (!valid_i) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          addr_sh_q <= '0;
          data_sh_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slave_bus_port.sv
// tb_slave_bus_port: drives serial frames into a latency-1 and a latency-3 slave port side by side
// and compares every cycle against frame timing and a shadow memory.
module tb_slave_bus_port;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic valid = 1'b0, address = 1'b0, data = 1'b0;
  logic rdy1, do1, we1, re1, rdy3, do3, we3, re3;
  logic [11:0] addr1, addr3;
  logic [7:0]  wd1, wd3, rd1, rd3;
  bit   [7:0]  mem1 [4096];
  bit   [7:0]  mem3 [4096];
  bit   [7:0]  ref_mem [4096];
  logic [7:0]  rp1;
  logic [7:0]  rp3 [3];
  logic [11:0] prev_addr = '0;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  slave_bus_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid), .address_i(address), .data_i(data),
    .ready_o(rdy1), .data_out_o(do1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
    .mem_we_o(we1), .mem_re_o(re1), .mem_rdata_i(rd1));

  slave_bus_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid), .address_i(address), .data_i(data),
    .ready_o(rdy3), .data_out_o(do3), .mem_addr_o(addr3), .mem_wdata_o(wd3),
    .mem_we_o(we3), .mem_re_o(re3), .mem_rdata_i(rd3));

  // Memories return garbage except exactly READ_LATENCY cycles after a read strobe.
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    rp1 <= re1 ? mem1[addr1] : 8'($urandom);
  end
  assign rd1 = rp1;

  always @(posedge clk) begin
    if (we3) mem3[addr3] <= wd3;
    rp3[0] <= re3 ? mem3[addr3] : 8'($urandom);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rd3 = rp3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_inst(input string n, input int lat, input int j, input bit full, input bit rw,
                          input logic [11:0] a, input logic [7:0] d, input logic [7:0] exp_rd,
                          input logic we, input logic re, input logic rdy, input logic dout,
                          input logic [11:0] addr, input logic [7:0] wd);
    bit e_rdy, e_do;
    e_rdy = full && (rw ? (j == 14) : (j >= 14 + lat && j <= 21 + lat));
    e_do  = (e_rdy && !rw) ? exp_rd[j - 14 - lat] : 1'b0;
    check($sformatf("%s_we_c%0d", n, j), we, full && rw && j == 13);
    check($sformatf("%s_re_c%0d", n, j), re, full && !rw && j == 13);
    check($sformatf("%s_ready_c%0d", n, j), rdy, e_rdy);
    check($sformatf("%s_dout_c%0d", n, j), dout, e_do);
    check($sformatf("%s_addr_c%0d", n, j), addr, (full && j >= 13) ? a : prev_addr);
    if (full && rw && j == 13) check($sformatf("%s_wdata", n), wd, d);
  endtask

  task automatic check_reset(input string n);
    check({n, "_rst1_ready"}, rdy1, 0);
    check({n, "_rst1_dout"}, do1, 0);
    check({n, "_rst1_we"}, we1, 0);
    check({n, "_rst1_re"}, re1, 0);
    check({n, "_rst1_addr"}, addr1, 0);
    check({n, "_rst3_ready"}, rdy3, 0);
    check({n, "_rst3_dout"}, do3, 0);
    check({n, "_rst3_we"}, we3, 0);
    check({n, "_rst3_re"}, re3, 0);
    check({n, "_rst3_addr"}, addr3, 0);
  endtask

  // Called at a falling edge; cycle k is the period that ends at rising edge k.
  task automatic run_frame(input bit rw, input logic [11:0] a, input logic [7:0] d,
                           input int abort_at, input int rst_at, input bit hold);
    logic [7:0] exp_rd;
    bit full;
    int j;
    exp_rd = ref_mem[a];
    full = (abort_at == 0);
    for (int k = 0; k <= 25; k++) begin
      data = 1'($urandom);
      address = 1'($urandom);
      if (k == 0) begin
        valid = 1'b1;
        address = rw;
      end else if (k <= 12) begin
        valid = !(abort_at != 0 && k >= abort_at);
        address = a[k-1];
        if (k <= 8) data = d[k-1];
      end else begin
        valid = full && hold;
      end
      @(posedge clk);
      @(negedge clk);
      j = k + 1;
      if (j == rst_at) begin
        rst_ni = 1'b0;
        #1;
        check_reset("midtx");
        prev_addr = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        valid = 1'b0;
        return;
      end
      cmp_inst("L1", 1, j, full, rw, a, d, exp_rd, we1, re1, rdy1, do1, addr1, wd1);
      cmp_inst("L3", 3, j, full, rw, a, d, exp_rd, we3, re3, rdy3, do3, addr3, wd3);
    end
    if (full) begin
      prev_addr = a;
      if (rw) ref_mem[a] = d;
    end
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    @(negedge clk);
    check_reset("init");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_frame(1, 12'h2A5, 8'h3C, 0, 0, 0);
    run_frame(1, 12'h0F0, 8'hA7, 0, 0, 0);
    run_frame(0, 12'h0F0, 8'h00, 0, 0, 0);
    run_frame(1, 12'h123, 8'h55, 6, 0, 0);
    run_frame(1, 12'hFFF, 8'hFF, 0, 0, 0);
    run_frame(1, 12'h2A5, 8'h3C, 0, 0, 1);
    run_frame(0, 12'hFFF, 8'h00, 0, 0, 0);
    run_frame(0, 12'h0F0, 8'h00, 0, 18, 0);
    run_frame(1, 12'h001, 8'h81, 0, 0, 0);
    run_frame(0, 12'h001, 8'h00, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 0;
      run_frame(1'($urandom), 12'($urandom_range(0, 31)), 8'($urandom), ab, 0, 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
